// File: rtl/mem_access_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_pkg
//
// Shared definitions for the load/store memory access unit:
//   - RAM_WORDS_DEFAULT : default depth (in 32-bit words) of the downstream ram
//   - F3_*              : access-size encodings carried on req_funct3
//   - state_t           : state encoding of the access FSM
//   - access_error()    : decides whether a request must be rejected without
//                         touching the ram (bad size code, signed/unsigned
//                         size on a store, misalignment, or out-of-range word)
// ----------------------------------------------------------------------------
package mem_access_pkg;

    localparam int RAM_WORDS_DEFAULT = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    // BU/HU only make sense for loads, so a store carrying them is rejected
    // just like the unused size codes.
    function automatic logic access_error(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int          ram_words
    );
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_BU:   err = we;
            F3_H:    err = addr[0];
            F3_HU:   err = we | addr[0];
            F3_W:    err = (addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(ram_words)) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// ----------------------------------------------------------------------------
// mem_lane
//
// Purely combinational byte-lane helper for the memory access unit.
//
// Ports:
//   funct3    in  3   access size (B, H, W, BU, HU)
//   offset    in  2   byte offset within the word (addr[1:0])
//   word      in  32  word read from the ram
//   wdata     in  32  right-aligned store data
//   load_data out 32  selected lane, sign/zero-extended (W passes through)
//   merged    out 32  word with only the addressed byte/half replaced by
//                     wdata[7:0] / wdata[15:0]; unchanged for other sizes
// ----------------------------------------------------------------------------
module mem_lane
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b    = 8'h00;
        lane_h    = 16'h0000;
        load_data = 32'h0000_0000;
        merged    = word;

        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase

        // Halfword alignment is checked upstream, so only offset[1] matters.
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h000000, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0000, lane_h};
            F3_W:    load_data = word;
            default: load_data = 32'h0000_0000;
        endcase

        case (funct3)
            F3_B: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Turns core load/store requests of byte, halfword or word size into
// word-wide accesses on a simple ram port. Sub-word stores are done as a
// read-modify-write so the ram only ever sees full-word writes.
//
// Parameters:
//   RAM_WORDS   number of 32-bit words in the downstream ram
//
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   req_valid   in   core presents a request
//   req_ready   out  unit can accept a request (IDLE only)
//   req_we      in   1 = store, 0 = load
//   req_funct3  in   access size code
//   req_addr    in   byte address
//   req_wdata   in   right-aligned store data
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  extended load result (0 for stores/errors)
//   resp_err    out  request rejected, ram untouched
//   ram_a       out  word-aligned ram address
//   ram_we      out  ram write enable
//   ram_re      out  ram read enable
//   ram_wd      out  ram write data
//   ram_rd      in   ram read data (combinational from ram_a)
// ----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int RAM_WORDS = RAM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_a,
    output logic        ram_we,
    output logic        ram_re,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;

    logic [31:0] load_data;
    logic [31:0] merged;

    // Gating with rst_n keeps ready low while reset is held and lets it rise
    // as soon as reset is released, without waiting for a clock edge.
    assign req_ready = rst_n && (state == IDLE);

    mem_lane u_lane (
        .funct3    (funct3_q),
        .offset    (offset_q),
        .word      (ram_rd),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Access FSM. Every output is registered together with the state, so each
    // branch sets the outputs belonging to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            funct3_q   <= 3'b000;
            offset_q   <= 2'b00;
            wdata_q    <= 32'h0000_0000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
            ram_a      <= 32'h0000_0000;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            ram_wd     <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= req_funct3;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        if (access_error(req_we, req_funct3, req_addr, RAM_WORDS)) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            state  <= LOAD;
                            ram_re <= 1'b1;
                            ram_a  <= {req_addr[31:2], 2'b00};
                        end else if (req_funct3 == F3_W) begin
                            state  <= WRITE;
                            ram_we <= 1'b1;
                            ram_a  <= {req_addr[31:2], 2'b00};
                            ram_wd <= req_wdata;
                        end else begin
                            state  <= RMW_RD;
                            ram_re <= 1'b1;
                            ram_a  <= {req_addr[31:2], 2'b00};
                        end
                    end
                end

                LOAD: begin
                    state      <= RESP;
                    ram_re     <= 1'b0;
                    ram_a      <= 32'h0000_0000;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                end

                // The merged word is captured here so the WRITE cycle does not
                // depend on ram_rd, which is only valid while ram_re is high.
                RMW_RD: begin
                    state  <= WRITE;
                    ram_re <= 1'b0;
                    ram_we <= 1'b1;
                    ram_wd <= merged;
                end

                WRITE: begin
                    state      <= RESP;
                    ram_we     <= 1'b0;
                    ram_a      <= 32'h0000_0000;
                    ram_wd     <= 32'h0000_0000;
                    resp_valid <= 1'b1;
                end

                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0000_0000;
                end

                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0000_0000;
                    ram_a      <= 32'h0000_0000;
                    ram_we     <= 1'b0;
                    ram_re     <= 1'b0;
                    ram_wd     <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. A behavioural ram sits on the ram
// port; a separate reference copy of the memory plus arithmetic size/shift
// rules predicts every response, latency and resulting memory word.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int RAM_WORDS = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_a;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;

    logic [31:0] mem     [RAM_WORDS];
    logic [31:0] ref_mem [RAM_WORDS];

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata;

    mem_access_unit #(.RAM_WORDS(RAM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_a      (ram_a),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_wd     (ram_wd),
        .ram_rd     (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram: combinational read, write on the rising edge.
    assign ram_rd = (ram_re && (ram_a[31:2] < RAM_WORDS)) ? mem[ram_a[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we && (ram_a[31:2] < RAM_WORDS)) begin
            mem[ram_a[7:2]] <= ram_wd;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference rules, written from the access-size definitions.
    function automatic bit ref_error(input bit we, input bit [2:0] f3, input bit [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
        if ((a / 4) >= RAM_WORDS) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ref_bytes(input bit [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a, input logic [31:0] w);
        longint unsigned mask, v;
        int n, sh;
        n    = ref_bytes(f3);
        sh   = 8 * int'(a % 4);
        mask = (64'd1 << (8 * n)) - 1;
        v    = (longint'(w) >> sh) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input bit [2:0] f3, input bit [31:0] a,
                                              input logic [31:0] old, input logic [31:0] wd);
        longint unsigned mask, v;
        int sh;
        sh   = 8 * int'(a % 4);
        mask = ((64'd1 << (8 * ref_bytes(f3))) - 1) << sh;
        v    = (longint'(old) & ~mask) | ((longint'(wd) << sh) & mask);
        return v[31:0];
    endfunction

    task automatic apply_stimulus(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // Waits (bounded) until the unit is ready, then lets the accept edge pass.
    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_accept_timeout"}, 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Follows one accepted request to its response and checks everything the
    // reference model predicts about it, then updates the model.
    task automatic observe(input string tag, input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        bit err;
        int exp_lat, exp_re, exp_we, lat, re_n, we_n, idx;
        bit bad_a, stray;
        logic [31:0] exp_rdata;
        err     = ref_error(we, f3, a);
        idx     = int'(a / 4);
        exp_lat = err ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
        exp_re  = err ? 0 : ((!we || f3 != 3'd2) ? 1 : 0);
        exp_we  = (!err && we) ? 1 : 0;
        exp_rdata = (err || we) ? 32'h0 : ref_load(f3, a, ref_mem[idx]);
        lat = 0; re_n = 0; we_n = 0; bad_a = 0; stray = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            if (ram_re) re_n++;
            if (ram_we) we_n++;
            if ((ram_re || ram_we) && ram_a !== {a[31:2], 2'b00}) bad_a = 1;
            if (resp_err || resp_rdata != 0) stray = 1;
        end
        check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check_output({tag, "_resp_err"}, 32'(resp_err), 32'(err));
        check_output({tag, "_rdata"}, resp_rdata, exp_rdata);
        check_output({tag, "_ram_re_cycles"}, 32'(re_n), 32'(exp_re));
        check_output({tag, "_ram_we_cycles"}, 32'(we_n), 32'(exp_we));
        check_output({tag, "_ram_a"}, 32'(bad_a), 32'd0);
        check_output({tag, "_quiet_before_resp"}, 32'(stray), 32'd0);
        check_output({tag, "_resp_ram_idle"}, {ram_re, ram_we, (ram_a != 0), (ram_wd != 0)}, 32'd0);
        last_rdata = resp_rdata;
        @(negedge clk);
        check_output({tag, "_pulse_end"}, {resp_valid, resp_err, (resp_rdata != 0)}, 32'd0);
        check_output({tag, "_ready_again"}, 32'(req_ready), 32'd1);
        if (!err && we) begin
            ref_mem[idx] = ref_store(f3, a, ref_mem[idx], wd);
            check_output({tag, "_mem_word"}, mem[idx], ref_mem[idx]);
        end
    endtask

    task automatic do_req(input string tag, input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        apply_stimulus(we, f3, a, wd);
        wait_accept(tag);
        req_valid = 1'b0;
        observe(tag, we, f3, a, wd);
    endtask

    initial begin
        logic [31:0] keep;
        bit [2:0] f3_tab [11];
        bit rw;
        bit [2:0] rf3;
        bit [31:0] ra;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        for (int i = 0; i < RAM_WORDS; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        apply_stimulus(1'b0, 3'd0, 32'h0, 32'h0);
        req_valid = 1'b0;
        #2;

        // Reset state
        check_output("reset_ready_low", 32'(req_ready), 32'd0);
        check_output("reset_outputs", {resp_valid, resp_err, ram_we, ram_re}, 32'd0);
        check_output("reset_words", resp_rdata | ram_a | ram_wd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Word store then load
        do_req("sw_10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        check_output("sw_10_word4", mem[4], 32'hDEADBEEF);
        do_req("lw_10", 1'b0, 3'd2, 32'h10, 32'h0);
        check_output("lw_10_value", last_rdata, 32'hDEADBEEF);

        // Sub-word loads
        do_req("lb_13", 1'b0, 3'd0, 32'h13, 32'h0);
        check_output("lb_13_value", last_rdata, 32'hFFFFFFDE);
        do_req("lbu_13", 1'b0, 3'd4, 32'h13, 32'h0);
        check_output("lbu_13_value", last_rdata, 32'h000000DE);
        do_req("lh_10", 1'b0, 3'd1, 32'h10, 32'h0);
        check_output("lh_10_value", last_rdata, 32'hFFFFBEEF);
        do_req("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0);
        check_output("lhu_12_value", last_rdata, 32'h0000DEAD);

        // Byte read-modify-write
        do_req("sb_11", 1'b1, 3'd0, 32'h11, 32'h00000055);
        check_output("sb_11_word4", mem[4], 32'hDEAD55EF);

        // Rejected requests
        do_req("err_lw_12", 1'b0, 3'd2, 32'h12, 32'h0);
        do_req("err_sh_11", 1'b1, 3'd1, 32'h11, 32'h1234);
        do_req("err_sb_100", 1'b1, 3'd0, 32'h100, 32'hAA);
        do_req("err_store_bu", 1'b1, 3'd4, 32'h14, 32'hAA);
        check_output("err_mem_word4", mem[4], 32'hDEAD55EF);

        // Reset while in the read half of a byte store
        do_req("sw_20", 1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
        keep = mem[8];
        apply_stimulus(1'b1, 3'd0, 32'h20, 32'h77);
        wait_accept("sb_20_rst");
        @(negedge clk);
        check_output("sb_20_in_rmw_rd", 32'(ram_re), 32'd1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("rst_mid_outputs", {resp_valid, resp_err, ram_we, ram_re, req_ready}, 32'd0);
        check_output("rst_mid_words", resp_rdata | ram_a | ram_wd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rst_release_ready", 32'(req_ready), 32'd1);
        begin
            bit seen;
            seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid || ram_we) seen = 1;
            end
            check_output("rst_no_response", 32'(seen), 32'd0);
        end
        check_output("rst_word8_kept", mem[8], keep);
        check_output("rst_word8_model", mem[8], ref_mem[8]);

        // Back-to-back with req_valid held high across both requests
        apply_stimulus(1'b1, 3'd2, 32'h30, 32'h13579BDF);
        wait_accept("b2b_a");
        apply_stimulus(1'b0, 3'd2, 32'h30, 32'h0);
        observe("b2b_a", 1'b1, 3'd2, 32'h30, 32'h13579BDF);
        wait_accept("b2b_b");
        req_valid = 1'b0;
        observe("b2b_b", 1'b0, 3'd2, 32'h30, 32'h0);
        check_output("b2b_b_value", last_rdata, 32'h13579BDF);
        begin
            bit extra;
            extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid || !req_ready) extra = 1;
            end
            check_output("b2b_no_duplicate", 32'(extra), 32'd0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = f3_tab[$urandom_range(0, 10)];
            ra  = 32'($urandom_range(0, RAM_WORDS * 4 + 11));
            if ($urandom_range(0, 3) != 0) begin
                ra = ra & ~(32'(ref_bytes(rf3)) - 32'd1);
            end
            do_req($sformatf("rnd%0d", i), rw, rf3, ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
